// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBR/TLBWI/TLBWR/TLBP against a 16-entry TLB; also maintains the Random register.
// Optional: define TLB_PROBE_EARLY_EXIT_EN to end a probe on the first matching entry.
module tlb_op_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        opValid,
    input  logic [1:0]  opCode,
    output logic        opReady,
    output logic        opDone,
    input  logic [31:0] cp0EntryHi,
    input  logic [31:0] cp0EntryLo0,
    input  logic [31:0] cp0EntryLo1,
    input  logic [3:0]  cp0Index,
    input  logic [3:0]  cp0Wired,
    output logic [83:0] tlbConfig,
    output logic        tlbwi,
    output logic [3:0]  tlbRdIndex,
    input  logic [79:0] tlbRdEntry,
    output logic [31:0] probeResult,
    output logic        probeWe,
    output logic [31:0] readEntryHi,
    output logic [31:0] readLo0,
    output logic [31:0] readLo1,
    output logic        readWe,
    output logic [3:0]  random
);
    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

    typedef enum logic [2:0] {IDLE, WRITE, READ, PROBE, DONE} stateT;

    stateT       stateReg, stateNext;
    logic [1:0]  opReg;
    logic [18:0] vpn2Reg;
    logic [7:0]  asidReg;
    logic [3:0]  indexReg;
    logic [3:0]  probeKReg;
    logic        hitReg;
    logic [3:0]  hitIdxReg;

    logic        accept;
    logic        isWriteOp;
    logic [79:0] newEntry;
    logic [3:0]  writeIndex;
    logic [7:0]  rdAsid;
    logic        rdG;
    logic [18:0] rdVpn2;
    logic [23:0] rdPfn1, rdPfn0;
    logic        rdD1, rdV1, rdD0, rdV0;
    logic        probeMatch;
    logic        hitNow;
    logic [3:0]  hitIdxNow;
    logic        unusedBits;

    assign accept     = opValid && (stateReg == IDLE);
    assign isWriteOp  = (opCode == OP_TLBWI) || (opCode == OP_TLBWR);
    assign writeIndex = (opCode == OP_TLBWI) ? cp0Index : random;
    assign newEntry   = {cp0EntryHi[7:0], cp0EntryLo0[0] & cp0EntryLo1[0], cp0EntryHi[31:13],
                         cp0EntryLo1[29:6], cp0EntryLo1[2], cp0EntryLo1[1],
                         cp0EntryLo0[29:6], cp0EntryLo0[2], cp0EntryLo0[1]};
    assign unusedBits = &{1'b0, cp0EntryHi[12:8], cp0EntryLo0[31:30], cp0EntryLo0[5:3],
                          cp0EntryLo1[31:30], cp0EntryLo1[5:3]};

    assign {rdAsid, rdG, rdVpn2, rdPfn1, rdD1, rdV1, rdPfn0, rdD0, rdV0} = tlbRdEntry;

    // Only the lowest matching index survives: once hitReg is set, later matches are ignored.
    assign probeMatch = (rdVpn2 == vpn2Reg) && (rdG || (rdAsid == asidReg));
    assign hitNow     = hitReg || probeMatch;
    assign hitIdxNow  = hitReg ? hitIdxReg : probeKReg;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    case (opCode)
                        OP_TLBR:  stateNext = READ;
                        OP_TLBP:  stateNext = PROBE;
                        default:  stateNext = WRITE;
                    endcase
                end
            end
            WRITE: stateNext = DONE;
            READ:  stateNext = DONE;
            PROBE: begin
`ifdef TLB_PROBE_EARLY_EXIT_EN
                if (probeMatch || (probeKReg == 4'd15)) stateNext = DONE;
`else
                if (probeKReg == 4'd15) stateNext = DONE;
`endif
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Strobes decode from state so an asynchronous reset drops them at once.
    always_comb begin
        opReady    = (stateReg == IDLE);
        opDone     = (stateReg == DONE);
        tlbwi      = (stateReg == WRITE);
        probeWe    = (stateReg == DONE) && (opReg == OP_TLBP);
        readWe     = (stateReg == DONE) && (opReg == OP_TLBR);
        tlbRdIndex = 4'd0;
        if (stateReg == READ)  tlbRdIndex = indexReg;
        if (stateReg == PROBE) tlbRdIndex = probeKReg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            opReg       <= OP_TLBR;
            vpn2Reg     <= '0;
            asidReg     <= '0;
            indexReg    <= '0;
            probeKReg   <= '0;
            hitReg      <= 1'b0;
            hitIdxReg   <= '0;
            tlbConfig   <= '0;
            probeResult <= '0;
            readEntryHi <= '0;
            readLo0     <= '0;
            readLo1     <= '0;
            random      <= 4'd15;
        end else begin
            stateReg <= stateNext;
            random   <= (random <= cp0Wired) ? 4'd15 : random - 4'd1;
            if (accept) begin
                opReg     <= opCode;
                vpn2Reg   <= cp0EntryHi[31:13];
                asidReg   <= cp0EntryHi[7:0];
                indexReg  <= cp0Index;
                probeKReg <= 4'd0;
                hitReg    <= 1'b0;
                if (isWriteOp) tlbConfig <= {newEntry, writeIndex};
            end
            if (stateReg == READ) begin
                readEntryHi <= {rdVpn2, 5'b0, rdAsid};
                readLo1     <= {2'b0, rdPfn1, 3'b0, rdD1, rdV1, rdG};
                readLo0     <= {2'b0, rdPfn0, 3'b0, rdD0, rdV0, rdG};
            end
            if (stateReg == PROBE) begin
                probeKReg <= probeKReg + 4'd1;
                hitReg    <= hitNow;
                hitIdxReg <= hitIdxNow;
                if (stateNext == DONE)
                    probeResult <= hitNow ? {28'b0, hitIdxNow} : 32'h8000_0000;
            end
        end
    end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: a field-level TLB model predicts every op, a monitor checks completions.
module tb_tlb_op_ctrl;
    typedef struct packed {
        logic [7:0]  asid;
        logic        g;
        logic [18:0] vpn2;
        logic [23:0] pfn1;
        logic        d1;
        logic        v1;
        logic [23:0] pfn0;
        logic        d0;
        logic        v0;
    } entryT;
    typedef struct {
        logic [1:0]  kind;
        int          doneCyc;
        logic [31:0] pr;
        logic [31:0] rh;
        logic [31:0] rl0;
        logic [31:0] rl1;
    } expT;
    typedef struct {
        int          cyc;
        logic [83:0] cfg;
    } wrT;

    logic        clk, rst_n, opValid, opReady, opDone, tlbwi, probeWe, readWe;
    logic [1:0]  opCode;
    logic [31:0] cp0EntryHi, cp0EntryLo0, cp0EntryLo1;
    logic [3:0]  cp0Index, cp0Wired, tlbRdIndex, randomOut;
    logic [83:0] tlbConfig;
    logic [79:0] tlbRdEntry;
    logic [31:0] probeResult, readEntryHi, readLo0, readLo1;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    entryT model[16];
    logic [79:0] tlbMem[16];
    logic  loadMem = 1'b0;
    logic [3:0] modelRandom;
    expT   expQ[$];
    wrT    wrQ[$];

    tlb_op_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opValid(opValid), .opCode(opCode), .opReady(opReady),
        .opDone(opDone), .cp0EntryHi(cp0EntryHi), .cp0EntryLo0(cp0EntryLo0),
        .cp0EntryLo1(cp0EntryLo1), .cp0Index(cp0Index), .cp0Wired(cp0Wired),
        .tlbConfig(tlbConfig), .tlbwi(tlbwi), .tlbRdIndex(tlbRdIndex), .tlbRdEntry(tlbRdEntry),
        .probeResult(probeResult), .probeWe(probeWe), .readEntryHi(readEntryHi),
        .readLo0(readLo0), .readLo1(readLo1), .readWe(readWe), .random(randomOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The TLB array the controller drives.
    assign tlbRdEntry = tlbMem[tlbRdIndex];
    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 16; i++) tlbMem[i] <= model[i];
        end else if (tlbwi) begin
            tlbMem[tlbConfig[3:0]] <= tlbConfig[83:4];
        end
    end

    // Random counts down each cycle and reloads 15 once it has reached Wired.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelRandom <= 4'd15;
        else        modelRandom <= (modelRandom <= cp0Wired) ? 4'd15 : modelRandom - 4'd1;
    end

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic noteFail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic entryT mkEntry(input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        entryT e;
        e.asid = hi[7:0];
        e.g    = lo0[0] & lo1[0];
        e.vpn2 = hi[31:13];
        e.pfn1 = lo1[29:6];
        e.d1   = lo1[2];
        e.v1   = lo1[1];
        e.pfn0 = lo0[29:6];
        e.d0   = lo0[2];
        e.v0   = lo0[1];
        return e;
    endfunction

    always @(negedge clk) begin
        wrT  w;
        expT e;
        check("random", randomOut, modelRandom);
        if (tlbwi) begin
            if (wrQ.size() == 0) noteFail("spurious_tlbwi");
            else begin
                w = wrQ.pop_front();
                check("tlbwi_cycle", cyc, w.cyc);
                check("tlbConfig", tlbConfig, w.cfg);
            end
        end
        if (opDone) begin
            if (expQ.size() == 0) noteFail("spurious_opDone");
            else begin
                e = expQ.pop_front();
                check("done_cycle", cyc, e.doneCyc);
                check("probeWe", probeWe, e.kind == 2'b11);
                check("readWe", readWe, e.kind == 2'b00);
                if (e.kind == 2'b11) check("probeResult", probeResult, e.pr);
                if (e.kind == 2'b00) begin
                    check("readEntryHi", readEntryHi, e.rh);
                    check("readLo0", readLo0, e.rl0);
                    check("readLo1", readLo1, e.rl1);
                end
            end
        end else begin
            check("idle_we", {probeWe, readWe}, 0);
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (!opReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!opReady) noteFail("ready_timeout");
    endtask

    // Called at a negedge; the op is accepted in the current cycle.
    task automatic issue(input logic [1:0] code, input logic [31:0] hi, input logic [31:0] lo0,
                         input logic [31:0] lo1, input logic [3:0] idx);
        expT   e;
        wrT    w;
        entryT ent;
        logic [3:0] wi;
        int    hit;
        waitIdle();
        if (!opReady) return;
        opValid = 1'b1; opCode = code;
        cp0EntryHi = hi; cp0EntryLo0 = lo0; cp0EntryLo1 = lo1; cp0Index = idx;
        e.kind = code; e.pr = '0; e.rh = '0; e.rl0 = '0; e.rl1 = '0;
        e.doneCyc = cyc + 2;
        case (code)
            2'b01, 2'b10: begin
                wi  = (code == 2'b01) ? idx : modelRandom;
                ent = mkEntry(hi, lo0, lo1);
                model[wi] = ent;
                w.cyc = cyc + 1;
                w.cfg = {ent, wi};
                wrQ.push_back(w);
            end
            2'b00: begin
                ent   = model[idx];
                e.rh  = {ent.vpn2, 5'b0, ent.asid};
                e.rl1 = {2'b0, ent.pfn1, 3'b0, ent.d1, ent.v1, ent.g};
                e.rl0 = {2'b0, ent.pfn0, 3'b0, ent.d0, ent.v0, ent.g};
            end
            default: begin
                hit = -1;
                for (int i = 0; i < 16; i++)
                    if (hit < 0 && model[i].vpn2 == hi[31:13] && (model[i].g || model[i].asid == hi[7:0]))
                        hit = i;
                e.pr = (hit < 0) ? 32'h8000_0000 : 32'(hit);
                e.doneCyc = cyc + 17;
`ifdef TLB_PROBE_EARLY_EXIT_EN
                if (hit >= 0) e.doneCyc = cyc + hit + 2;
`endif
            end
        endcase
        expQ.push_back(e);
        $display("op code=%0d hi=%h lo0=%h lo1=%h idx=%0d accept_cyc=%0d expect_done=%0d",
                 code, hi, lo0, lo1, idx, cyc, e.doneCyc);
        @(negedge clk);
        opValid = 1'b0;
        cp0EntryHi = $urandom; cp0EntryLo0 = $urandom; cp0EntryLo1 = $urandom;
        cp0Index = 4'($urandom_range(0, 15));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r0, r1, r2;
        logic [1:0]  code;
        logic [18:0] vX;
        rst_n = 1'b0; opValid = 1'b0; opCode = 2'b00;
        cp0EntryHi = '0; cp0EntryLo0 = '0; cp0EntryLo1 = '0; cp0Index = '0; cp0Wired = '0;
        for (int i = 0; i < 16; i++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            r0[31] = 1'b0;
            model[i] = mkEntry(r0, r1, r2);
        end
        loadMem = 1'b1;
        @(posedge clk); #1;
        loadMem = 1'b0;
        check("rst_opReady", opReady, 1);
        check("rst_strobes", {opDone, tlbwi, probeWe, readWe}, 0);
        check("rst_tlbConfig", tlbConfig, 0);
        check("rst_rdIndex", tlbRdIndex, 0);
        check("rst_results", {probeResult, readEntryHi, readLo0, readLo1}, 0);
        check("rst_random", randomOut, 15);

        cp0Wired = 4'd4;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("random_first", randomOut, 14);
        repeat (20) @(negedge clk);

        issue(2'b01, 32'h0040_2012, 32'h0000_0047, 32'h0000_0087, 4'd5);
        issue(2'b00, 32'h0, 32'h0, 32'h0, 4'd5);
        waitIdle();
        check("tlbr_hi_const", readEntryHi, 32'h0040_2012);
        check("tlbr_lo0_const", readLo0, 32'h0000_0047);
        check("tlbr_lo1_const", readLo1, 32'h0000_0087);

        vX = 19'h7ABCD;
        issue(2'b01, {vX, 5'b0, 8'h11}, 32'h0000_0106, 32'h0000_0147, 4'd3);
        issue(2'b01, {vX, 5'b0, 8'h22}, 32'h0000_0207, 32'h0000_0247, 4'd7);
        issue(2'b11, {vX, 5'b0, 8'h33}, 32'h0, 32'h0, 4'd0);
        repeat (3) @(negedge clk);
        opValid = 1'b1; opCode = 2'b01;
        @(negedge clk);
        opValid = 1'b0;
        waitIdle();
        check("probe_hit_const", probeResult, 32'd7);
        issue(2'b11, {19'h7FFFF, 5'b0, 8'h33}, 32'h0, 32'h0, 4'd0);
        waitIdle();
        check("probe_miss_const", probeResult, 32'h8000_0000);

        // Reset lands while the write strobe is up: the entry must stay untouched.
        waitIdle();
        cp0EntryHi = 32'hDEAD_A0FF; cp0EntryLo0 = 32'h0123_4567; cp0EntryLo1 = 32'h0765_4321;
        cp0Index = 4'd9; opCode = 2'b01; opValid = 1'b1;
        $display("op code=1 idx=9 accept_cyc=%0d reset during write", cyc);
        @(posedge clk); #2;
        opValid = 1'b0;
        check("rst_tlbwi_before", tlbwi, 1);
        rst_n = 1'b0; #1;
        check("rst_tlbwi_drop", tlbwi, 0);
        check("rst_ready_again", opReady, 1);
        check("rst_random_again", randomOut, 15);
        check("rst_tlbConfig_again", tlbConfig, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'h0, 32'h0, 32'h0, 4'd9);

        for (int t = 0; t < 80; t++) begin
            code = 2'($urandom_range(0, 3));
            r0 = $urandom;
            if ($urandom_range(0, 1) == 1) r0[31:13] = model[$urandom_range(0, 15)].vpn2;
            if ($urandom_range(0, 7) == 0) cp0Wired = 4'($urandom_range(0, 15));
            issue(code, r0, $urandom, $urandom, 4'($urandom_range(0, 15)));
        end

        waitIdle();
        repeat (3) @(negedge clk);
        check("queues_empty", expQ.size() + wrQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
